sm_accum_ctrl: RTL

SM_ACCUM_CTRL -- requirements
Module: sm_accum_ctrl

---
 rtl/sm_accum_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sm_accum_ctrl.sv
// Sign-magnitude frame accumulator: sums DEG messages per frame in two's
// complement, tracks the smallest magnitude, and hands the result downstream
// over a valid/ready handshake with a sticky framing-error flag.
module sm_accum_ctrl #(
    parameter int W     = 6,
    parameter int DEG   = 6,
    parameter int ACC_W = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [W-1:0]     i_data,
    input  logic             i_valid,
    input  logic             i_last,
    output logic             o_ready,
    input  logic             i_flush,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_hard,
    output logic [W-2:0]     o_min_mag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_err
);

    localparam int CNT_W = $clog2(DEG + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [W-2:0]     min_mag;
    logic [ACC_W-1:0] sum_reg;
    logic [W-2:0]     min_mag_reg;
    logic             err_reg;

    logic             accept;
    logic             transfer;
    logic             do_flush;

    // Message decode: negative zero is treated as +0, so the complement and
    // the carry-in are both gated by a non-zero magnitude.
    logic [W-2:0]     mag;
    logic             negate;
    logic [ACC_W-1:0] mag_ext;
    logic [ACC_W-1:0] conv;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] count_inc;
    logic             last_beat;
    logic [W-2:0]     min_sel;

    assign mag       = i_data[W-2:0];
    assign negate    = i_data[W-1] & (mag != '0);
    assign mag_ext   = {{(ACC_W-W+1){1'b0}}, mag};
    assign conv      = (mag_ext ^ {ACC_W{negate}}) + {{(ACC_W-1){1'b0}}, negate};
    assign acc_sum   = acc + conv;
    assign count_inc = count + CNT_W'(1);
    assign last_beat = (count_inc == CNT_W'(DEG));
    assign min_sel   = ((count == '0) || (mag < min_mag)) ? mag : min_mag;

    assign o_sum     = sum_reg;
    assign o_hard    = sum_reg[ACC_W-1];
    assign o_min_mag = min_mag_reg;
    assign o_err     = err_reg;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; a flush wins over a beat in the same cycle.
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        accept     = 1'b0;
        transfer   = 1'b0;
        do_flush   = 1'b0;
        case (state)
            S_IDLE, S_ACC: begin
                o_ready = 1'b1;
                if (i_flush) begin
                    do_flush   = 1'b1;
                    state_next = S_IDLE;
                end else if (i_valid) begin
                    accept     = 1'b1;
                    state_next = last_beat ? S_OUT : S_ACC;
                end
            end
            S_OUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    transfer   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Accumulator, beat count, running minimum and registered result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc         <= '0;
            count       <= '0;
            min_mag     <= '1;
            sum_reg     <= '0;
            min_mag_reg <= '1;
        end else if (do_flush || transfer) begin
            acc     <= '0;
            count   <= '0;
            min_mag <= '1;
        end else if (accept) begin
            acc     <= acc_sum;
            count   <= count_inc;
            min_mag <= min_sel;
            if (last_beat) begin
                sum_reg     <= acc_sum;
                min_mag_reg <= min_sel;
            end
        end
    end

    // Sticky framing error: i_last must coincide exactly with the DEG-th beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_reg <= 1'b0;
        end else if (accept && (i_last != last_beat)) begin
            err_reg <= 1'b1;
        end
    end

endmodule
